cache_controller: RTL and testbench

- Sits between the MEM stage and the 2-way data cache / SRAM controller.
- Services MEM-stage loads from the cache on a hit. On a miss it fetches a 64-bit line from SRAM and fills the cache.
- Stores are write-through to SRAM; a matching cache line is invalidated.
- Drives `ready`, which freezes the pipeline while SRAM is busy.

---
 rtl/cache_controller_pkg.sv | 21 ++
 rtl/cache_controller_sat_counter.sv | 19 +
 rtl/cache_controller.sv | 121 ++++++++++++
 tb/tb_cache_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the MEM-stage cache controller.
// Holds the FSM state encoding, the data-memory base and the cache address field layout.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam int unsigned DATA_BASE = 1024;

  // Word address into the cache: {tag, index, word-in-line}
  localparam int unsigned TAG_MSB  = 16;
  localparam int unsigned TAG_LSB  = 7;
  localparam int unsigned IDX_MSB  = 6;
  localparam int unsigned IDX_LSB  = 1;
  localparam int unsigned WORD_BIT = 0;
  localparam int unsigned CADDR_W  = TAG_MSB + 1;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Load/store controller between the MEM stage and a 2-way data cache backed by SRAM.
// Loads hit in zero cycles, misses fetch a 64-bit line; stores write through and invalidate.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned DATA_BASE = cache_controller_pkg::DATA_BASE,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               ready,
  output logic [CADDR_W-1:0] cache_addr,
  output logic               cache_r_en,
  output logic               cache_w_en,
  output logic               cache_invoke_en,
  output logic [63:0]        cache_wdata,
  input  logic               cache_hit,
  input  logic [31:0]        cache_rdata,
  output logic               sram_r_en,
  output logic               sram_w_en,
  output logic [31:0]        sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [63:0]        sram_rdata,
  input  logic               sram_ready,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  state_t state, next_state;
  logic   hit_inc, miss_inc;

  assign cache_addr = CADDR_W'((mem_addr - 32'(DATA_BASE)) >> 2);
  assign sram_addr  = mem_addr;
  assign sram_wdata = mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from state and request; reset suppresses every side effect.
  always_comb begin
    next_state      = state;
    ready           = 1'b1;
    mem_rdata       = '0;
    cache_r_en      = 1'b0;
    cache_w_en      = 1'b0;
    cache_invoke_en = 1'b0;
    cache_wdata     = '0;
    sram_r_en       = 1'b0;
    sram_w_en       = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (mem_w_en) begin
            ready           = 1'b0;
            sram_w_en       = 1'b1;
            cache_invoke_en = cache_hit;
            next_state      = WR_WAIT;
          end else if (mem_r_en) begin
            if (cache_hit) begin
              cache_r_en = 1'b1;
              mem_rdata  = cache_rdata;
              hit_inc    = 1'b1;
            end else begin
              ready      = 1'b0;
              sram_r_en  = 1'b1;
              miss_inc   = 1'b1;
              next_state = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          sram_r_en = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            cache_w_en  = 1'b1;
            cache_wdata = sram_rdata;
            mem_rdata   = cache_addr[WORD_BIT] ? sram_rdata[63:32] : sram_rdata[31:0];
            ready       = 1'b1;
            next_state  = IDLE;
          end
        end
        WR_WAIT: begin
          sram_w_en = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            ready      = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: expected load data and SRAM write data are queued
// at issue and compared when the controller completes the request.
module tb_cache_controller;

  localparam int unsigned CNT_W = 2;

  logic              clk;
  logic              rst;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              ready;
  logic [16:0]       cache_addr;
  logic              cache_r_en;
  logic              cache_w_en;
  logic              cache_invoke_en;
  logic [63:0]       cache_wdata;
  logic              cache_hit;
  logic [31:0]       cache_rdata;
  logic              sram_r_en;
  logic              sram_w_en;
  logic [31:0]       sram_addr;
  logic [31:0]       sram_wdata;
  logic [63:0]       sram_rdata;
  logic              sram_ready;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp32;

  cache_controller #(.DATA_BASE(1024), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .ready           (ready),
    .cache_addr      (cache_addr),
    .cache_r_en      (cache_r_en),
    .cache_w_en      (cache_w_en),
    .cache_invoke_en (cache_invoke_en),
    .cache_wdata     (cache_wdata),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .sram_r_en       (sram_r_en),
    .sram_w_en       (sram_w_en),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .sram_ready      (sram_ready),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'd1024; mem_wdata = '0;
    cache_hit = 1'b0; cache_rdata = '0; sram_rdata = '0; sram_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    checks++; if ({sram_r_en, sram_w_en, cache_r_en, cache_w_en, cache_invoke_en} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got %b want 00000", {sram_r_en, sram_w_en, cache_r_en, cache_w_en, cache_invoke_en}); end
    checks++; if ({hit_cnt, miss_cnt} !== 4'b0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_load_hit();
    mem_addr = 32'd1024; mem_r_en = 1'b1; cache_hit = 1'b1; cache_rdata = 32'hCAFE_F00D;
    rd_q.push_back(32'hCAFE_F00D);
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hit_ready got %b want 1", ready); end
    checks++; if (cache_r_en !== 1'b1) begin errors++; $display("FAIL hit_cache_r_en got %b want 1", cache_r_en); end
    checks++; if (cache_addr !== 17'h0) begin errors++; $display("FAIL hit_cache_addr got %h want 0", cache_addr); end
    exp32 = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
    checks++; if (mem_rdata !== exp32) begin errors++; $display("FAIL hit_rdata got %h want %h", mem_rdata, exp32); end
    cycle();
    mem_r_en = 1'b0; cache_hit = 1'b0;
    #2;
    checks++; if (hit_cnt !== 2'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
    checks++; if (miss_cnt !== 2'd0) begin errors++; $display("FAIL hit_miss_cnt got %0d want 0", miss_cnt); end
  endtask

  task automatic test_load_miss();
    cycle();
    mem_addr = 32'd1028; mem_r_en = 1'b1; cache_hit = 1'b0;
    rd_q.push_back(32'hBBBB_0000);
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++; if ({ready, sram_r_en, cache_w_en} !== 3'b010) begin
        errors++; $display("FAIL miss_stall%0d got ready/sram_r_en/cache_w_en=%b want 010", k, {ready, sram_r_en, cache_w_en}); end
      cycle();
    end
    sram_ready = 1'b1; sram_rdata = {32'hBBBB_0000, 32'hAAAA_0000};
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL miss_ready got %b want 1", ready); end
    checks++; if (cache_w_en !== 1'b1) begin errors++; $display("FAIL miss_fill got %b want 1", cache_w_en); end
    checks++; if (cache_addr !== 17'h1) begin errors++; $display("FAIL miss_cache_addr got %h want 1", cache_addr); end
    checks++; if (cache_wdata !== 64'hBBBB_0000_AAAA_0000) begin errors++; $display("FAIL miss_wdata got %h want bbbb0000aaaa0000", cache_wdata); end
    exp32 = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
    checks++; if (mem_rdata !== exp32) begin errors++; $display("FAIL miss_rdata got %h want %h", mem_rdata, exp32); end
    cycle();
    sram_ready = 1'b0; mem_r_en = 1'b0;
    #2;
    checks++; if (miss_cnt !== 2'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", miss_cnt); end
    checks++; if (hit_cnt !== 2'd1) begin errors++; $display("FAIL miss_hit_cnt got %0d want 1", hit_cnt); end
    checks++; if ({ready, sram_r_en} !== 2'b10) begin errors++; $display("FAIL miss_back_idle got %b want 10", {ready, sram_r_en}); end
  endtask

  task automatic test_store(input logic hit);
    cycle();
    mem_addr = 32'd1024; mem_w_en = 1'b1; mem_wdata = 32'h1234; cache_hit = hit;
    wr_q.push_back(32'h1234);
    #2;
    checks++; if ({ready, sram_w_en} !== 2'b01) begin errors++; $display("FAIL store%0d_first got ready/sram_w_en=%b want 01", hit, {ready, sram_w_en}); end
    checks++; if (cache_invoke_en !== hit) begin errors++; $display("FAIL store%0d_invoke got %b want %b", hit, cache_invoke_en, hit); end
    checks++; if (sram_addr !== 32'd1024) begin errors++; $display("FAIL store%0d_addr got %h want 400", hit, sram_addr); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      #2;
      checks++; if ({ready, sram_w_en, cache_invoke_en, cache_w_en} !== 4'b0100) begin
        errors++; $display("FAIL store%0d_wait%0d got %b want 0100", hit, k, {ready, sram_w_en, cache_invoke_en, cache_w_en}); end
    end
    cycle();
    sram_ready = 1'b1;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL store%0d_ready got %b want 1", hit, ready); end
    exp32 = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hxxxx_xxxx;
    checks++; if (sram_wdata !== exp32) begin errors++; $display("FAIL store%0d_wdata got %h want %h", hit, sram_wdata, exp32); end
    cycle();
    sram_ready = 1'b0; mem_w_en = 1'b0; cache_hit = 1'b0;
    #2;
    checks++; if ({ready, sram_w_en, hit_cnt, miss_cnt} !== {2'b10, 2'd1, 2'd1}) begin
      errors++; $display("FAIL store%0d_after got %b want 100101", hit, {ready, sram_w_en, hit_cnt, miss_cnt}); end
  endtask

  task automatic test_reset_mid_miss();
    cycle();
    mem_addr = 32'd1032; mem_r_en = 1'b1; cache_hit = 1'b0;
    cycle(); cycle();
    rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'h1111_2222_3333_4444;
    #2;
    checks++; if (cache_w_en !== 1'b0) begin errors++; $display("FAIL rstmiss_fill got %b want 0", cache_w_en); end
    cycle();
    rst = 1'b0; mem_r_en = 1'b0; sram_ready = 1'b0;
    #2;
    checks++; if ({ready, sram_r_en, cache_w_en} !== 3'b100) begin errors++; $display("FAIL rstmiss_idle got %b want 100", {ready, sram_r_en, cache_w_en}); end
    checks++; if ({hit_cnt, miss_cnt} !== 4'b0) begin errors++; $display("FAIL rstmiss_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    cycle();
    #2;
    checks++; if (sram_r_en !== 1'b0) begin errors++; $display("FAIL rstmiss_stays_idle got %b want 0", sram_r_en); end
  endtask

  task automatic test_back_to_back_saturation();
    cycle();
    mem_r_en = 1'b1; cache_hit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_addr = 32'd1024 + 32'(i * 4);
      cache_rdata = 32'h5000_0000 + 32'(i);
      rd_q.push_back(32'h5000_0000 + 32'(i));
      #2;
      exp32 = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
      checks++; if ({ready, mem_rdata} !== {1'b1, exp32}) begin
        errors++; $display("FAIL b2b%0d got ready=%b rdata=%h want ready=1 rdata=%h", i, ready, mem_rdata, exp32); end
      cycle();
    end
    mem_r_en = 1'b0; cache_hit = 1'b0;
    #2;
    checks++; if (hit_cnt !== 2'd3) begin errors++; $display("FAIL sat_hit_cnt got %0d want 3", hit_cnt); end
  endtask

  task automatic test_simultaneous_and_idle_ready();
    cycle();
    mem_addr = 32'd1024; mem_r_en = 1'b1; mem_w_en = 1'b1; mem_wdata = 32'hDEAD_BEEF; cache_hit = 1'b1;
    #2;
    checks++; if ({ready, sram_w_en, sram_r_en, cache_r_en, cache_invoke_en} !== 5'b01001) begin
      errors++; $display("FAIL rw_first got %b want 01001", {ready, sram_w_en, sram_r_en, cache_r_en, cache_invoke_en}); end
    cycle();
    sram_ready = 1'b1;
    #2;
    checks++; if ({ready, sram_wdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rw_done got ready=%b wdata=%h want ready=1 wdata=deadbeef", ready, sram_wdata); end
    cycle();
    mem_r_en = 1'b0; mem_w_en = 1'b0; cache_hit = 1'b0;
    // sram_ready held high while idle must not start or complete anything
    #2;
    checks++; if ({ready, cache_w_en, sram_r_en, sram_w_en} !== 4'b1000) begin
      errors++; $display("FAIL idle_sram_ready got %b want 1000", {ready, cache_w_en, sram_r_en, sram_w_en}); end
    checks++; if ({hit_cnt, miss_cnt} !== {2'd3, 2'd0}) begin errors++; $display("FAIL rw_counters got %0d/%0d want 3/0", hit_cnt, miss_cnt); end
    cycle();
    sram_ready = 1'b0;
    #2;
    checks++; if ({ready, sram_w_en, sram_r_en} !== 3'b100) begin errors++; $display("FAIL idle_after got %b want 100", {ready, sram_w_en, sram_r_en}); end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_load_miss();
    test_store(1'b1);
    test_store(1'b0);
    test_reset_mid_miss();
    test_back_to_back_saturation();
    test_simultaneous_and_idle_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
